// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - carry-save multi-operand stream accumulator with iterative resolve
module csa_stream_accumulator #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_c;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;

    logic [W-1:0]  w_x;
    logic [W-1:0]  w_csa_s;
    logic [W-1:0]  w_csa_c;
    logic [CW-1:0] w_cnt_inc;
    logic          w_xfer;

    assign w_x       = W'(in_data);
    assign w_csa_s   = r_s ^ r_c ^ w_x;
    assign w_csa_c   = ((r_s & r_c) | (r_s & w_x) | (r_c & w_x)) << 1;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
    assign w_xfer    = r_out_valid && out_ready;

    // Handshake flags are pure decodes of registered state, so no input reaches them combinationally.
    assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_s;
    assign out_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s     <= w_x;
                        r_c     <= '0;
                        r_cnt   <= CW'(1);
                        r_state <= in_last ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_s   <= w_csa_s;
                        r_c   <= w_csa_c;
                        r_cnt <= w_cnt_inc;
                        if (in_last) begin
                            r_state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    if (r_c == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_s <= r_s ^ r_c;
                        r_c <= (r_s & r_c) << 1;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE and drops on the transfer.
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - directed table-driven bench for csa_stream_accumulator
module tb_csa_stream_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [7:0] out_count;
    logic       busy;

    int checks;
    int errors;

    csa_stream_accumulator #(.N(4), .W(8), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ops holds up to four nibbles, beat i uses nibble min(i,3); exp_lat < 0 skips the latency check.
    typedef struct {
        int          n;
        logic [15:0] ops;
        logic [7:0]  exp_sum;
        logic [7:0]  exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_packet(input vec_t v, output int lat);
        int idx;
        for (int i = 0; i < v.n; i++) begin
            idx      = (i < 4) ? i : 3;
            in_valid = 1'b1;
            in_data  = v.ops[4*idx +: 4];
            in_last  = (i == v.n - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int lat;
        send_packet(v, lat);
        if (v.exp_lat >= 0) chk($sformatf("latency[%0d]", k), lat, v.exp_lat);
        chk($sformatf("out_sum[%0d]", k), {24'd0, out_sum}, {24'd0, v.exp_sum});
        chk($sformatf("out_count[%0d]", k), {24'd0, out_count}, {24'd0, v.exp_cnt});
        chk($sformatf("busy_done[%0d]", k), {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("single_pulse[%0d]", k), {31'd0, out_valid}, 32'd0);
        chk($sformatf("in_ready_idle[%0d]", k), {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out_sum"}, {24'd0, out_sum}, 32'd0);
        chk({tag, "_out_count"}, {24'd0, out_count}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   lat;
        checks    = 0;
        errors    = 0;
        vecs[0] = '{n: 4,   ops: 16'h3F5A, exp_sum: 8'h21, exp_cnt: 8'd4,   exp_lat: -1};
        vecs[1] = '{n: 1,   ops: 16'h0000, exp_sum: 8'h00, exp_cnt: 8'd1,   exp_lat: 2};
        vecs[2] = '{n: 2,   ops: 16'h001F, exp_sum: 8'h10, exp_cnt: 8'd2,   exp_lat: 6};
        vecs[3] = '{n: 18,  ops: 16'hFFFF, exp_sum: 8'h0E, exp_cnt: 8'd18,  exp_lat: -1};
        vecs[4] = '{n: 300, ops: 16'h1111, exp_sum: 8'h2C, exp_cnt: 8'hFF,  exp_lat: -1};
        vecs[5] = '{n: 3,   ops: 16'h0987, exp_sum: 8'h18, exp_cnt: 8'd3,   exp_lat: -1};
        vecs[6] = '{n: 1,   ops: 16'h0005, exp_sum: 8'h05, exp_cnt: 8'd1,   exp_lat: 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Backpressure: result held in DONE while out_ready is low, new beats refused.
        out_ready = 1'b0;
        v = '{n: 2, ops: 16'h0062, exp_sum: 8'h08, exp_cnt: 8'd2, exp_lat: -1};
        send_packet(v, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
            in_last  = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_valid[%0d]", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_sum[%0d]", c), {24'd0, out_sum}, 32'h08);
            chk($sformatf("bp_count[%0d]", c), {24'd0, out_count}, 32'd2);
            chk($sformatf("bp_in_ready[%0d]", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_sum", {24'd0, out_sum}, 32'h08);

        // Reset mid-ACCUM.
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_busy_accum", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_accum");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-RESOLVE: 0xF,0x1 needs four carry iterations.
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_data = 4'h1;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_in_ready_resolve", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_resolve");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        v = '{n: 2, ops: 16'h0043, exp_sum: 8'h07, exp_cnt: 8'd2, exp_lat: -1};
        run_vec(v, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand adder. Accepts a packet of N-bit operands over a valid/ready stream.
- Each accepted operand is folded into a redundant (sum, carry) pair, one carry-save step per beat. There is no carry propagation during accumulation.
- After the last operand, the pair is resolved iteratively into a binary W-bit result, which is returned on a valid/ready output stream together with the operand count.
- Sits in the adders library as the sequencer around the carry-save stage datapath.

Parameters:
- N, 4, input operand width.
- W, 8, accumulator/result width (W >= N). The result is the operand sum modulo 2^W.
- CW, 8, operand-count width. The count saturates at 2^CW-1.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, N, operand, zero-extended to W.
- in_last, input, 1, marks the final operand of a packet.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_sum, output, W, resolved sum mod 2^W.
- out_count, output, CW, operands in the packet (saturating).
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Internal registers: state, S[W-1:0], C[W-1:0], cnt[CW-1:0].
- Reset: asynchronous on rst_n=0, from any state, including mid-packet or mid-resolve. Result: state=IDLE, S=0, C=0, cnt=0, in_ready=1, out_valid=0, busy=0. out_sum=0 and out_count=0, because both are driven from S and cnt.
- A beat is accepted when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready.
- CSA step for operand X = zext(in_data):
  - S' = S ^ C ^ X
  - C' = ((S&C)|(S&X)|(C&X)) << 1, truncated to W bits (MSB carry discarded).
  - Invariant: S+C ≡ sum of accepted operands (mod 2^W).
- IDLE: in_ready=1. On an accepted beat: S<=X, C<=0, cnt<=1. Next state is RESOLVE if in_last, else ACCUM.
- ACCUM: in_ready=1. On an accepted beat: apply the CSA step and set cnt<=cnt+1, holding at 2^CW-1 once reached. Go to RESOLVE if in_last. With no beat, all registers hold.
- RESOLVE: in_ready=0.
  - If C==0, go to DONE.
  - Otherwise S<=S^C and C<=(S&C)<<1 (truncated).
  - Terminates in at most W iterations.
- DONE: out_valid=1, out_sum=S, out_count=cnt, all stable while out_ready=0. in_ready=0. On an output transfer, go to IDLE; out_valid drops the next cycle.
- Latency: the last beat is accepted at edge k.
  - A packet whose C is already 0 asserts out_valid after edge k+2.
  - Each nonzero-carry resolve iteration adds one cycle.
- Simultaneous events:
  - in_valid is ignored in RESOLVE and DONE, because in_ready=0.
  - A new packet may be presented the cycle after the output transfer (IDLE).
- in_data and in_last are sampled only on accepted beats. in_last is ignored when in_valid=0.
- Wrap-around: bits above W-1 are discarded silently; no overflow flag.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Test Plan (N=4, W=8, CW=8):
- Operands 0xA, 0x5, 0xF, 0x3 (last on 0x3), out_ready=1 -> out_sum=0x21, out_count=4, one out_valid pulse.
- Single operand 0x0 with last, accepted at edge k -> out_valid after edge k+2, out_sum=0x00, out_count=1.
- Operands 0xF then 0x1 (last) -> 4 nonzero resolve iterations, then out_sum=0x10, out_count=2, out_valid after edge k+6.
- 18 operands of 0xF -> out_sum=0x0E (270 mod 256), out_count=18. Run 300 operands of 0x1 -> out_sum=0x2C, out_count=0xFF (saturated).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_count stable, in_ready=0, in_valid beats not accepted. Then out_ready=1 -> IDLE, in_ready=1.
- Assert rst_n=0 mid-ACCUM and again mid-RESOLVE -> immediate IDLE with all outputs at reset values. The next packet 0x3, 0x4 (last) gives out_sum=0x07, out_count=2.
